sram_port_arbiter: RTL and testbench

- Shares one single-port synchronous SRAM between NUM_REQ requesters, e.g. the matcher vocab scan and a controller writing the output RAM.
- Uses round-robin arbitration with an optional lock, so a requester can hold the port across a multi-cycle burst (a full vocabulary scan).
- Sits between the requesters and the `sram` instance; each cycle it drives exactly one access onto the SRAM, or none.
- Routes the one-cycle-late read data back to the requester that issued the read.

---
 rtl/sram_port_arbiter.sv | 79 +++++++
 tb/tb_sram_port_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin arbiter with burst lock that shares one single-port SRAM
// among NUM_REQ requesters and steers the one-cycle-late read data back to the reader.
module sram_port_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ-1:0]            lock_i,
   input  logic [NUM_REQ-1:0]            we_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
   output logic [NUM_REQ-1:0]            gnt_o,
   output logic [NUM_REQ-1:0]            rvalid_o,
   output logic [DATA_WIDTH-1:0]         rdata_o,
   output logic                          mem_cs_o,
   output logic                          mem_we_o,
   output logic [ADDR_WIDTH-1:0]         mem_addr_o,
   output logic [DATA_WIDTH-1:0]         mem_din_o,
   input  logic [DATA_WIDTH-1:0]         mem_dout_i
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   logic [IW-1:0]      ptr_q, ptr_d, owner_q, owner_d, sel;
   logic               owned_q, owned_d, hit, any;
   logic [NUM_REQ-1:0] rsel_q, rsel_d;
   int                 j;
   // a held lock overrides the rotating search
   always_comb begin
      sel = ptr_q;
      hit = 1'b0;
      j   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(ptr_q) + k) % NUM_REQ;
         if (!hit && req_i[j[IW-1:0]]) begin
            hit = 1'b1;
            sel = j[IW-1:0];
         end
      end
      if (owned_q && req_i[owner_q] && lock_i[owner_q]) begin
         hit = 1'b1;
         sel = owner_q;
      end
   end
   assign any        = hit && rst_n;
   assign gnt_o      = any ? NUM_REQ'(1) << sel : '0;
   assign mem_cs_o   = any;
   assign mem_we_o   = any && we_i[sel];
   assign mem_addr_o = any ? addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH] : '0;
   assign mem_din_o  = any ? wdata_i[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign rvalid_o   = rsel_q;
   assign rdata_o    = mem_dout_i;
   always_comb begin
      ptr_d   = ptr_q;
      owner_d = owner_q;
      owned_d = 1'b0;
      rsel_d  = gnt_o & ~we_i;
      if (any && lock_i[sel]) begin
         owner_d = sel;
         owned_d = 1'b1;
      end else if (any) begin
         ptr_d = (sel == IW'(NUM_REQ-1)) ? '0 : sel + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         owner_q <= '0;
         owned_q <= 1'b0;
         rsel_q  <= '0;
      end else begin
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         owned_q <= owned_d;
         rsel_q  <= rsel_d;
      end
   end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: vector table, directed multi-cycle sequences and a randomized run
// against a reference model for the SRAM port arbiter.
module tb_sram_port_arbiter;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [1:0]  req = '0, lock = '0, we = '0, gnt, rvalid;
   logic [7:0]  addr = '0, rdata, mem_din, mem_dout = '0;
   logic [15:0] wdata = '0;
   logic        mem_cs, mem_we;
   logic [3:0]  mem_addr;
   logic [7:0]  mem [16];
   logic [2:0]  req3 = '0, gnt3, rv3;
   logic [7:0]  rd3, din3;
   logic [3:0]  ma3;
   logic        cs3, we3;
   int          pass = 0, total = 0;

   always #5 clk = ~clk;

   sram_port_arbiter dut (
      .clk(clk), .rst_n(rst_n), .req_i(req), .lock_i(lock), .we_i(we), .addr_i(addr),
      .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .mem_cs_o(mem_cs),
      .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_din_o(mem_din), .mem_dout_i(mem_dout));

   sram_port_arbiter #(.NUM_REQ(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .req_i(req3), .lock_i(3'b000), .we_i(3'b000), .addr_i(12'h000),
      .wdata_i(24'h000000), .gnt_o(gnt3), .rvalid_o(rv3), .rdata_o(rd3), .mem_cs_o(cs3),
      .mem_we_o(we3), .mem_addr_o(ma3), .mem_din_o(din3), .mem_dout_i(8'h00));

   always @(posedge clk)
      if (mem_cs) begin
         if (mem_we) mem[mem_addr] <= mem_din;
         else mem_dout <= mem[mem_addr];
      end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; req = 2'b11; lock = '0; we = '0; addr = 8'h55; wdata = 16'h1234; req3 = 3'b111;
      #1;
      chk("reset_gnt", 32'(gnt), 0);
      chk("reset_mem", 32'({mem_cs, mem_we, mem_addr, mem_din}), 0);
      chk("reset_rvalid", 32'(rvalid), 0);
      chk("reset_gnt3", 32'(gnt3), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1; req = '0; addr = '0; wdata = '0; req3 = '0;
   endtask

   typedef struct {
      logic [1:0] req, lock, we; logic [7:0] addr; logic [15:0] wdata;
      logic [1:0] gnt; logic mwe; logic [3:0] maddr; logic [7:0] mdin; logic [1:0] rv; logic [7:0] rd;
   } vec_t;
   vec_t tv[8];

   int         ptr, owner, g, gi;
   bit         owned;
   logic [1:0] erv, eg, cr, cl, cw;
   logic [7:0] erd, gold [16];
   logic [3:0] ca [2];
   logic [7:0] cd [2];
   logic [1:0] rr [4];

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
      mem[3] = 8'h5A;
      tv[0] = '{2'b01, 2'b00, 2'b00, 8'h03, 16'h0000, 2'b01, 1'b0, 4'h3, 8'h00, 2'b00, 8'h00};
      tv[1] = '{2'b00, 2'b00, 2'b00, 8'h00, 16'h0000, 2'b00, 1'b0, 4'h0, 8'h00, 2'b01, 8'h5A};
      tv[2] = '{2'b11, 2'b00, 2'b00, 8'h21, 16'h0000, 2'b10, 1'b0, 4'h2, 8'h00, 2'b00, 8'h00};
      tv[3] = '{2'b11, 2'b00, 2'b00, 8'h21, 16'h0000, 2'b01, 1'b0, 4'h1, 8'h00, 2'b10, 8'h12};
      tv[4] = '{2'b11, 2'b00, 2'b00, 8'h21, 16'h0000, 2'b10, 1'b0, 4'h2, 8'h00, 2'b01, 8'h11};
      tv[5] = '{2'b01, 2'b00, 2'b01, 8'h07, 16'h00C3, 2'b01, 1'b1, 4'h7, 8'hC3, 2'b10, 8'h12};
      tv[6] = '{2'b10, 2'b00, 2'b00, 8'h70, 16'h0000, 2'b10, 1'b0, 4'h7, 8'h00, 2'b00, 8'h00};
      tv[7] = '{2'b00, 2'b00, 2'b00, 8'h00, 16'h0000, 2'b00, 1'b0, 4'h0, 8'h00, 2'b10, 8'hC3};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         req = tv[i].req; lock = tv[i].lock; we = tv[i].we; addr = tv[i].addr; wdata = tv[i].wdata;
         #1;
         chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tv[i].gnt));
         chk($sformatf("vec%0d_mem", i), 32'({mem_cs, mem_we, mem_addr, mem_din}),
             32'({|tv[i].gnt, tv[i].mwe, tv[i].maddr, tv[i].mdin}));
         chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(tv[i].rv));
         if (tv[i].rv != 0) chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(tv[i].rd));
      end

      // round-robin from reset
      rr[0] = 2'b01; rr[1] = 2'b10; rr[2] = 2'b01; rr[3] = 2'b10;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         req = (k < 4) ? 2'b11 : 2'b00; we = '0; addr = 8'h54;
         #1;
         chk($sformatf("rr%0d_gnt", k), 32'(gnt), (k < 4) ? 32'(rr[k]) : 0);
         chk($sformatf("rr%0d_rvalid", k), 32'(rvalid), (k > 0) ? 32'(rr[k-1]) : 0);
      end

      // lock burst: requester 1 holds the port for 16 cycles, then releases
      do_reset();
      for (int k = 0; k < 17; k++) begin
         @(negedge clk);
         req = (k == 0) ? 2'b10 : 2'b11; lock = (k < 16) ? 2'b10 : 2'b00; we = '0;
         addr = {4'(k), 4'h0};
         #1;
         chk($sformatf("lock%0d_gnt", k), 32'(gnt), (k < 16) ? 32'h2 : 32'h1);
         chk($sformatf("lock%0d_rvalid", k), 32'(rvalid), (k > 0) ? 32'h2 : 0);
      end

      // wrap with three requesters, requester 1 idle
      rr[0] = 2'b01; rr[1] = 2'b00; rr[2] = 2'b01; rr[3] = 2'b00;
      do_reset();
      req = '0; lock = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         req3 = 3'b101;
         #1;
         chk($sformatf("wrap%0d_gnt3", k), 32'(gnt3), (k % 2 == 0) ? 32'h1 : 32'h4);
      end

      // reset in the middle of a read
      do_reset();
      @(negedge clk);
      req = 2'b01; we = '0; addr = 8'h03;
      #1;
      chk("midrst_gnt_before", 32'(gnt), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("midrst_gnt_during", 32'(gnt), 0);
      chk("midrst_cs_during", 32'(mem_cs), 0);
      @(posedge clk);
      #1;
      chk("midrst_rvalid", 32'(rvalid), 0);
      @(negedge clk);
      rst_n = 1'b1; req = 2'b11;
      #1;
      chk("midrst_gnt_after", 32'(gnt), 32'h1);
      chk("midrst_rvalid_after", 32'(rvalid), 0);

      // randomized run against the reference model
      do_reset();
      for (int i = 0; i < 16; i++) begin
         gold[i] = 8'($urandom);
         mem[i]  = gold[i];
      end
      ptr = 0; owner = 0; owned = 0; erv = '0; erd = '0; gi = -1; cr = '0; cw = '0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (!cr[i] || gi == i) begin
               cr[i] = ($urandom_range(0, 2) != 0);
               cw[i] = 1'($urandom_range(0, 1));
               ca[i] = 4'($urandom);
               cd[i] = 8'($urandom);
            end
            cl[i] = ($urandom_range(0, 3) == 0);
         end
         req = cr; lock = cl; we = cw; addr = {ca[1], ca[0]}; wdata = {cd[1], cd[0]};
         #1;
         g = -1;
         if (owned && cr[owner] && cl[owner]) g = owner;
         else for (int k = 0; k < 2; k++) if (g < 0 && cr[(ptr + k) % 2]) g = (ptr + k) % 2;
         eg = (g < 0) ? 2'b00 : 2'(1 << g);
         chk($sformatf("rnd%0d_gnt", n), 32'(gnt), 32'(eg));
         chk($sformatf("rnd%0d_mem", n), 32'({mem_cs, mem_we, mem_addr, mem_din}),
             (g < 0) ? 0 : 32'({1'b1, cw[g], ca[g], cd[g]}));
         chk($sformatf("rnd%0d_rvalid", n), 32'(rvalid), 32'(erv));
         if (erv != 0) chk($sformatf("rnd%0d_rdata", n), 32'(rdata), 32'(erd));
         erv = '0;
         if (g >= 0) begin
            if (cw[g]) gold[ca[g]] = cd[g];
            else begin
               erv = eg;
               erd = gold[ca[g]];
            end
            if (cl[g]) begin
               owner = g;
               owned = 1;
            end else begin
               owned = 0;
               ptr = (g + 1) % 2;
            end
         end else owned = 0;
         gi = g;
      end
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
